hex_entry_reg: RTL

// - Parametrised hex-digit entry register for the PDU; successor to the fixed 32-bit shift register.
// - Switch hex code plus add/del/set/clr/undo buttons edit a DIGITS-wide value, one action per press.
// - Tracks the number of entered digits, flags overflow, and keeps an UNDO_DEPTH history of prior values.
// - Feeds the PDU address/data/breakpoint entry path.

---
 rtl/hex_entry_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hex_entry_reg.sv
// Hex-digit entry register: button-driven edit of a DIGITS-wide value with
// digit count, sticky overflow and a circular UNDO_DEPTH history of {value,count}.
module hex_entry_reg #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned UNDO_DEPTH = 4,
  localparam int unsigned W  = 4 * DIGITS,
  localparam int unsigned CW = $clog2(DIGITS + 1),
  localparam int unsigned PW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1,
  localparam int unsigned OW = $clog2(UNDO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din,
  input  logic [3:0]    hex,
  input  logic          add,
  input  logic          del,
  input  logic          set,
  input  logic          clr,
  input  logic          undo,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] cnt,
  output logic          ovf,
  output logic          undo_avail
);

  logic [4:0]    btn;
  logic [4:0]    btn_q;
  logic [4:0]    btn_edge;
  logic          armed;

  logic [W-1:0]  hist_val [UNDO_DEPTH];
  logic [CW-1:0] hist_cnt [UNDO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_inc;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_d;

  logic [W-1:0]  add_val;
  logic [W-1:0]  del_val;
  logic [W-1:0]  dout_d;
  logic [CW-1:0] cnt_d;
  logic          ovf_d;
  logic          push;
  logic          pop;

  // armed stays low for the first post-reset edge so a button held through reset never acts
  assign btn      = {set, clr, add, del, undo};
  assign btn_edge = btn & ~btn_q & {5{armed}};

  // A single digit has no bits to shift through, so add replaces and del clears
  if (DIGITS == 1) begin : g_one_digit
    assign add_val = hex;
    assign del_val = '0;
  end else begin : g_multi_digit
    assign add_val = {dout[W-5:0], hex};
    assign del_val = {4'h0, dout[W-1:4]};
  end

  assign wr_ptr_inc = (wr_ptr == PW'(UNDO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign rd_ptr     = (wr_ptr == '0) ? PW'(UNDO_DEPTH - 1) : wr_ptr - PW'(1);

  // Operation select with priority set > clr > add > del > undo
  always_comb begin
    dout_d = dout;
    cnt_d  = cnt;
    ovf_d  = ovf;
    push   = 1'b0;
    pop    = 1'b0;
    if (btn_edge[4]) begin
      dout_d = din;
      cnt_d  = CW'(DIGITS);
      ovf_d  = 1'b0;
      push   = 1'b1;
    end else if (btn_edge[3]) begin
      dout_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      push   = 1'b1;
    end else if (btn_edge[2]) begin
      dout_d = add_val;
      push   = 1'b1;
      if (cnt == CW'(DIGITS)) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end else if (btn_edge[1]) begin
      if (cnt != '0) begin
        dout_d = del_val;
        cnt_d  = cnt - CW'(1);
        push   = 1'b1;
      end
    end else if (btn_edge[0]) begin
      if (occ != '0) begin
        dout_d = hist_val[rd_ptr];
        cnt_d  = hist_cnt[rd_ptr];
        pop    = 1'b1;
      end
    end
  end

  // Occupancy saturates at depth; a push when full overwrites the oldest slot
  always_comb begin
    occ_d = occ;
    if (push && (occ != OW'(UNDO_DEPTH))) begin
      occ_d = occ + OW'(1);
    end else if (pop) begin
      occ_d = occ - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q      <= '0;
      armed      <= 1'b0;
      dout       <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      undo_avail <= 1'b0;
      wr_ptr     <= '0;
      occ        <= '0;
      for (int i = 0; i < int'(UNDO_DEPTH); i++) begin
        hist_val[i] <= '0;
        hist_cnt[i] <= '0;
      end
    end else begin
      btn_q      <= btn;
      armed      <= 1'b1;
      dout       <= dout_d;
      cnt        <= cnt_d;
      ovf        <= ovf_d;
      occ        <= occ_d;
      undo_avail <= (occ_d != '0);
      if (push) begin
        hist_val[wr_ptr] <= dout;
        hist_cnt[wr_ptr] <= cnt;
        wr_ptr           <= wr_ptr_inc;
      end else if (pop) begin
        wr_ptr <= rd_ptr;
      end
    end
  end

endmodule
